// File: rtl/frame_pkg.sv
// Shared definitions for the RLE frame writer: FSM states, RLE byte fields
// and default frame geometry.
package frame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RUN,
      EMIT,
      DONE
   } state_t;

   localparam int VALUE_BIT = 7;
   localparam int LEN_MSB   = 6;
   localparam int LEN_W     = LEN_MSB + 1;

   localparam int DEFAULT_WIDTH  = 640;
   localparam int DEFAULT_HEIGHT = 480;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter with line wrap and last-pixel detection.
// The counter holds at the last pixel so neither coordinate leaves the frame.
module raster_counter
   import frame_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int HEIGHT = DEFAULT_HEIGHT,
   parameter int ADDRW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [ADDRW-1:0] x,
   output logic [ADDRW-1:0] y,
   output logic             last
);

   localparam logic [ADDRW-1:0] X_MAX = ADDRW'(WIDTH - 1);
   localparam logic [ADDRW-1:0] Y_MAX = ADDRW'(HEIGHT - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (advance && !last) begin
         if (x == X_MAX) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_writer.sv
// RLE decoder that writes a 1-bit frame buffer in raster order.
// Define FRAME_WRITER_OVERRUN_EN to build the sticky overrun flag.
module frame_writer
   import frame_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int HEIGHT = DEFAULT_HEIGHT,
   parameter int ADDRW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             we,
   output logic [ADDRW-1:0] addr_write_x,
   output logic [ADDRW-1:0] addr_write_y,
   output logic             data_in,
   output logic             frame_done,
   output logic             overrun
);

   state_t             state;
   logic [LEN_W-1:0]   count;
   logic [ADDRW-1:0]   x;
   logic [ADDRW-1:0]   y;
   logic               last;
   logic               start_frame;
   logic               advance;
   logic               handshake;

   assign start_frame  = (state == IDLE) && start;
   assign advance      = (state == EMIT);
   assign handshake    = s_valid && s_ready;
   assign addr_write_x = x;
   assign addr_write_y = y;

   raster_counter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .ADDRW (ADDRW)
   ) u_raster (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_frame),
      .advance(advance),
      .x      (x),
      .y      (y),
      .last   (last)
   );

   // count holds the pixels still to emit after the current one, so a run
   // ends on the EMIT cycle where it reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         s_ready    <= 1'b0;
         we         <= 1'b0;
         data_in    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= WAIT_RUN;
                  s_ready <= 1'b1;
               end
            end
            WAIT_RUN: begin
               if (handshake) begin
                  state   <= EMIT;
                  s_ready <= 1'b0;
                  we      <= 1'b1;
                  data_in <= s_data[VALUE_BIT];
                  count   <= s_data[LEN_MSB:0];
               end
            end
            EMIT: begin
               if (last) begin
                  state      <= DONE;
                  we         <= 1'b0;
                  frame_done <= 1'b1;
               end else if (count == '0) begin
                  state   <= WAIT_RUN;
                  we      <= 1'b0;
                  s_ready <= 1'b1;
               end else begin
                  count <= count - 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               frame_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               s_ready    <= 1'b0;
               we         <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef FRAME_WRITER_OVERRUN_EN
   logic overrun_q;

   // Pixels left in the run when the last pixel is written are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (start_frame) begin
         overrun_q <= 1'b0;
      end else if ((state == EMIT) && last && (count != '0)) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer on an 8x4 frame.
// Expected overrun follows FRAME_WRITER_OVERRUN_EN when that macro is defined.
module tb_frame_writer;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 3;
`ifdef FRAME_WRITER_OVERRUN_EN
   localparam int EXP_OVR = 1;
`else
   localparam int EXP_OVR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          we;
   logic [AW-1:0] addr_write_x;
   logic [AW-1:0] addr_write_y;
   logic          data_in;
   logic          frame_done;
   logic          overrun;

   typedef struct {
      int x;
      int y;
      int v;
      int cyc;
   } wr_t;

   wr_t wr_q[$];
   int  cyc = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   int  total = 0;
   int  bad = 0;

   frame_writer #(
      .WIDTH (W),
      .HEIGHT(H),
      .ADDRW (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .we          (we),
      .addr_write_x(addr_write_x),
      .addr_write_y(addr_write_y),
      .data_in     (data_in),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Logs every frame-buffer write and frame_done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (we) wr_q.push_back('{int'(addr_write_x), int'(addr_write_y), int'(data_in), cyc});
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   // Presents one RLE byte and holds it until the handshake edge.
   task automatic applyStimulus(input logic [7:0] b);
      waitReady("send");
      s_valid = 1'b1;
      s_data  = b;
      @(posedge clk);
      #1 s_valid = 1'b0;
      s_data = 8'h00;
   endtask

   task automatic expectWrite(input string tag, input int idx, input int ex, input int ey, input int ev);
      if (idx < wr_q.size())
         checkOutput($sformatf("%s_w%0d", tag, idx),
                     32'((wr_q[idx].x << 8) | (wr_q[idx].y << 4) | wr_q[idx].v),
                     32'((ex << 8) | (ey << 4) | ev));
      else
         checkOutput($sformatf("%s_w%0d_missing", tag, idx), 32'(wr_q.size()), 32'(idx + 1));
   endtask

   task automatic expectWrapPattern(input string tag);
      checkOutput({tag, "_count"}, 32'(wr_q.size()), 32'd10);
      for (int i = 0; i < 6; i++) expectWrite(tag, i, i, 0, 0);
      expectWrite(tag, 6, 6, 0, 1);
      expectWrite(tag, 7, 7, 0, 1);
      expectWrite(tag, 8, 0, 1, 1);
      expectWrite(tag, 9, 1, 1, 1);
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == 0) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_we", 32'(we), 32'd0);
      checkOutput("rst_ready", 32'(s_ready), 32'd0);
      checkOutput("rst_done", 32'(frame_done), 32'd0);
      checkOutput("rst_ovr", 32'(overrun), 32'd0);
      checkOutput("rst_xy", 32'({addr_write_x, addr_write_y, data_in}), 32'd0);
      rst = 1'b0;

      // Single run: 0x85 = value 1, six pixels
      pulseStart();
      applyStimulus(8'h85);
      @(negedge clk);
      checkOutput("run_first_we", 32'(we), 32'd1);
      checkOutput("run_first_addr", 32'({addr_write_x, addr_write_y, data_in}), 32'b000_000_1);
      waitReady("run");
      checkOutput("run_count", 32'(wr_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) expectWrite("run", i, i, 0, 1);

      // Reset mid-EMIT abandons the frame
      applyStimulus(8'h8F);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_we", 32'(we), 32'd0);
      checkOutput("midrst_ready", 32'(s_ready), 32'd0);
      checkOutput("midrst_done", 32'(frame_done), 32'd0);
      checkOutput("midrst_ovr", 32'(overrun), 32'd0);
      checkOutput("midrst_xy", 32'({addr_write_x, addr_write_y}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wr_q.delete();
      s_valid = 1'b1;
      s_data  = 8'hFF;
      repeat (10) @(negedge clk);
      s_valid = 1'b0;
      checkOutput("midrst_nowrite", 32'(wr_q.size()), 32'd0);
      checkOutput("midrst_idle_ready", 32'(s_ready), 32'd0);

      // Line wrap: six 0s then four 1s across the row boundary
      pulseStart();
      applyStimulus(8'h05);
      applyStimulus(8'h83);
      waitReady("wrap");
      expectWrapPattern("wrap");
      doReset();

      // Exact frame: 32 pixels, no overrun
      wr_q.delete();
      done_cnt = 0;
      pulseStart();
      applyStimulus(8'h9F);
      waitDone("exact");
      checkOutput("exact_count", 32'(wr_q.size()), 32'd32);
      for (int i = 0; i < 32; i++) expectWrite("exact", i, i % W, i / W, 1);
      if (wr_q.size() > 0)
         checkOutput("exact_done_lat", 32'(done_cyc), 32'(wr_q[wr_q.size()-1].cyc + 1));
      checkOutput("exact_ovr", 32'(overrun), 32'd0);
      @(negedge clk);
      checkOutput("exact_done_pulse", 32'(frame_done), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("exact_ready_after", 32'(s_ready), 32'd0);
      checkOutput("exact_done_cnt", 32'(done_cnt), 32'd1);

      // Overrun: 128-pixel run truncated at the last pixel
      wr_q.delete();
      done_cnt = 0;
      pulseStart();
      applyStimulus(8'hFF);
      waitDone("ovr");
      checkOutput("ovr_count", 32'(wr_q.size()), 32'd32);
      expectWrite("ovr", 31, 7, 3, 1);
      repeat (3) @(negedge clk);
      checkOutput("ovr_flag", 32'(overrun), 32'(EXP_OVR));
      checkOutput("ovr_nowrite", 32'(wr_q.size()), 32'd32);
      pulseStart();
      @(negedge clk);
      checkOutput("ovr_cleared", 32'(overrun), 32'd0);
      checkOutput("ovr_restart_ready", 32'(s_ready), 32'd1);
      doReset();

      // Random s_valid stalls with junk data and a stray start during EMIT
      wr_q.delete();
      pulseStart();
      begin
         logic [7:0] bytes[2];
         int idx = 0;
         int n = 0;
         bit start_sent = 0;
         bytes[0] = 8'h05;
         bytes[1] = 8'h83;
         while (idx < 2 && n < 400) begin
            @(negedge clk);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = s_ready ? bytes[idx] : 8'($urandom_range(0, 255));
            start   = (we && !start_sent);
            if (we) start_sent = 1;
            @(posedge clk);
            if (s_valid && s_ready) idx++;
            n++;
         end
         #1 s_valid = 1'b0;
         start = 1'b0;
         checkOutput("stall_consumed", 32'(idx), 32'd2);
         checkOutput("stall_start_sent", 32'(start_sent), 32'd1);
      end
      waitReady("stall");
      expectWrapPattern("stall");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
